nano_bus_fabric: RTL and testbench
==================================

# nano_bus_fabric

Parametrised memory-mapped interconnect between one nano2-style master port (address/writedata/readdata/read/write/waitrequest) and NSLAVE peripheral ports. It replaces hand-written chip-select and read-mux logic in the top level with a registered decode stage, per-slave address offsetting, an unmapped-address error response, and a bus-timeout watchdog. It sits between the core and the code RAM, data RAM, PIO, timer and UART peripherals.

## Interface
- NSLAVE, 4: number of slave ports (1..16)
- WIDTHA, 16: master address width (word addresses)
- WIDTHD, 32: data width
- BASE, packed NSLAVE×WIDTHA, {0}: base address of slave i at bits [i*WIDTHA +: WIDTHA]
- SIZE, packed NSLAVE×WIDTHA, {0}: window size of slave i in words; power of two, BASE aligned to SIZE
- ENABLE, NSLAVE bits, all 1: slave i decodes only if ENABLE[i]=1
- TIMEOUT, 256: maximum ACCESS cycles before forced completion; 0 disables the watchdog
- ERR_DATA, 32'hDEADBEEF: readdata returned on error completions

Ports:
- clock  in  1  system clock
- sreset  in  1  reset; one clock, synchronous, active-high
- m_address  in  WIDTHA  master word address
- m_writedata  in  WIDTHD  master write data
- m_read / m_write  in  1  master strobes, held until waitrequest low
- m_readdata  out  WIDTHD  read data, valid in the completion cycle
- m_waitrequest  out  1  stall master
- s_address  out  NSLAVE×WIDTHA  per-slave offset address (m_address − BASE[i])
- s_writedata  out  WIDTHD  broadcast write data
- s_read / s_write  out  NSLAVE  per-slave strobes, at most one bit set
- s_readdata  in  NSLAVE×WIDTHD  per-slave read data
- s_waitrequest  in  NSLAVE  per-slave stall
- err_clear  in  1  clears sticky error status
- err  out  1  sticky error flag
- err_code  out  2  0 none, 1 unmapped, 2 timeout, 3 read+write together
- err_address  out  WIDTHA  m_address of the first uncleared error

## Operation
- States: IDLE, ACCESS, ERROR.
- IDLE, no request: m_waitrequest=0, all s_read/s_write=0.
- IDLE, request (m_read|m_write): m_waitrequest=1; register sel = lowest i with ENABLE[i] and BASE[i] ≤ addr < BASE[i]+SIZE[i], and register offset = addr − BASE[i]. Hit → ACCESS. No hit, or m_read&m_write → ERROR.
- ACCESS: s_read[sel]=m_read, s_write[sel]=m_write, s_address[sel]=offset (other slaves' s_address=0); m_waitrequest=s_waitrequest[sel]; m_readdata=s_readdata[sel]. A cycle with s_waitrequest[sel]=0 completes the transfer → IDLE.
- Timeout: the cycle counter clears on entry to ACCESS. When it reaches TIMEOUT−1 with s_waitrequest[sel] still high, that cycle completes with m_waitrequest=0, m_readdata=ERR_DATA and strobes forced 0; err_code=2; → IDLE.
- ERROR: one cycle, m_waitrequest=0, m_readdata=ERR_DATA, no slave strobe, writes dropped, → IDLE.
- Error status: on an error completion with err=0, set err=1 and capture err_code and err_address. While err=1, later errors do not overwrite the capture. err_clear clears err, err_code and err_address; an error completing in the same cycle wins (status is set).
- Elaboration: overlapping enabled windows, non-power-of-two SIZE, or misaligned BASE → $error.

## Timing
- Reset: state IDLE, counter 0, err=0, err_code=0, err_address=0. While sreset=1: all s_read/s_write=0 and m_waitrequest=1. sreset during ACCESS abandons the transfer; strobes are low in that same cycle.
- Minimum latency: 2 cycles (decode cycle plus completion cycle) for a zero-wait slave. Back-to-back throughput is one transfer per 2 cycles.
- Slave wait of N cycles gives a total of N+2 cycles.
- m_readdata and m_waitrequest are combinational from the selected slave in ACCESS. Slave outputs need no registering.
- The master must deassert its strobes, or present a new request, in the cycle after completion. The IDLE state re-decodes every new request.

## Test plan
- NSLAVE=4, BASE={0,0x400,0x500,0x508}, SIZE={1024,256,8,8}. Read 0x412 from zero-wait RAM holding 0xCAFE0001 → s_read[1] high with s_address=0x12; m_readdata=0xCAFE0001 on cycle 2; m_waitrequest 1,0.
- Write 0x55 to 0x50B with slave 3 waiting 3 cycles → s_write[3] and offset 3 held for 4 cycles; total m_waitrequest high for 4 cycles.
- Read 0x7000 (unmapped) → no s_read, m_readdata=0xDEADBEEF on cycle 2, err=1, err_code=1, err_address=0x7000; a second unmapped read leaves err_address unchanged.
- TIMEOUT=16, slave 2 stuck with waitrequest high → completion on ACCESS cycle 16 with ERR_DATA, err_code=2; err_clear then clears err to 0.
- Raise sreset mid-ACCESS → strobes 0 in the same cycle; state IDLE and err=0 afterward; the next read completes normally.
- m_read and m_write asserted together → ERROR response, err_code=3; ENABLE[2]=0 makes 0x500 unmapped.

Source files
------------

// File: rtl/nano_bus_fabric.sv
// nano_bus_fabric: one nano2-style master to NSLAVE memory-mapped slaves.
// The address decode is registered, slave addresses are offset into each window, and unmapped or stalled accesses get an error response.
module nano_bus_fabric #(
  parameter int                         NSLAVE   = 4,
  parameter int                         WIDTHA   = 16,
  parameter int                         WIDTHD   = 32,
  parameter logic [NSLAVE*WIDTHA-1:0]   BASE     = '0,
  parameter logic [NSLAVE*WIDTHA-1:0]   SIZE     = '0,
  parameter logic [NSLAVE-1:0]          ENABLE   = '1,
  parameter int                         TIMEOUT  = 256,
  parameter logic [WIDTHD-1:0]          ERR_DATA = WIDTHD'(32'hDEADBEEF)
) (
  input  logic                     clock,
  input  logic                     sreset,
  input  logic [WIDTHA-1:0]        m_address,
  input  logic [WIDTHD-1:0]        m_writedata,
  input  logic                     m_read,
  input  logic                     m_write,
  output logic [WIDTHD-1:0]        m_readdata,
  output logic                     m_waitrequest,
  output logic [NSLAVE*WIDTHA-1:0] s_address,
  output logic [WIDTHD-1:0]        s_writedata,
  output logic [NSLAVE-1:0]        s_read,
  output logic [NSLAVE-1:0]        s_write,
  input  logic [NSLAVE*WIDTHD-1:0] s_readdata,
  input  logic [NSLAVE-1:0]        s_waitrequest,
  input  logic                     err_clear,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [WIDTHA-1:0]        err_address
);

  typedef enum logic [1:0] {IDLE, ACCESS, ERROR} state_t;

  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // A zero SIZE is treated as an empty window and never decodes.
  function automatic bit windows_overlap();
    longint unsigned bi, si, bj, sj;
    bit              ov;
    ov = 1'b0;
    for (int i = 0; i < NSLAVE; i++) begin
      for (int j = i + 1; j < NSLAVE; j++) begin
        bi = 64'(BASE[i*WIDTHA +: WIDTHA]);
        si = 64'(SIZE[i*WIDTHA +: WIDTHA]);
        bj = 64'(BASE[j*WIDTHA +: WIDTHA]);
        sj = 64'(SIZE[j*WIDTHA +: WIDTHA]);
        if (ENABLE[i] && ENABLE[j] && si != 0 && sj != 0 &&
            bi < bj + sj && bj < bi + si)
          ov = 1'b1;
      end
    end
    return ov;
  endfunction

  if (windows_overlap()) begin : g_overlap
    $error("nano_bus_fabric: enabled slave windows overlap");
  end

  state_t              state_reg, state_next;
  logic [NSLAVE-1:0]   sel_reg, sel_next;
  logic [WIDTHA-1:0]   offset_reg, offset_next;
  logic [WIDTHA-1:0]   addr_reg, addr_next;
  logic [1:0]          code_reg, code_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic                err_reg, err_next;
  logic [1:0]          err_code_reg, err_code_next;
  logic [WIDTHA-1:0]   err_address_reg, err_address_next;

  logic [NSLAVE-1:0]   hit;
  logic [NSLAVE-1:0]   pick;
  logic [WIDTHA-1:0]   slot_offset [NSLAVE];
  logic [WIDTHA-1:0]   pick_offset;
  logic                sel_wait;
  logic [WIDTHD-1:0]   sel_rdata;
  logic                timeout_hit;
  logic                err_event;
  logic [1:0]          err_event_code;

  genvar gi;
  generate
    for (gi = 0; gi < NSLAVE; gi++) begin : g_slot
      localparam logic [WIDTHA-1:0] B = BASE[gi*WIDTHA +: WIDTHA];
      localparam logic [WIDTHA-1:0] S = SIZE[gi*WIDTHA +: WIDTHA];
      localparam logic [WIDTHA-1:0] M = ~(S - WIDTHA'(1));

      if (S != '0 && (S & (S - WIDTHA'(1))) != '0) begin : g_bad_size
        $error("nano_bus_fabric: SIZE of slave %0d is not a power of two", gi);
      end
      if (S != '0 && (B & ~M) != '0) begin : g_bad_base
        $error("nano_bus_fabric: BASE of slave %0d is not aligned to SIZE", gi);
      end

      // Aligned power-of-two windows decode with a single masked compare.
      if (ENABLE[gi] && S != '0) begin : g_on
        assign hit[gi] = (m_address & M) == B;
      end else begin : g_off
        assign hit[gi] = 1'b0;
      end
      assign slot_offset[gi] = m_address - B;

      assign s_address[gi*WIDTHA +: WIDTHA] =
        (state_reg == ACCESS && sel_reg[gi]) ? offset_reg : '0;
    end
  endgenerate

  // Isolate the lowest-numbered hit so overlaps resolve deterministically.
  assign pick        = hit & (~hit + NSLAVE'(1));
  assign s_writedata = m_writedata;

  always_comb begin
    pick_offset = '0;
    sel_wait    = 1'b0;
    sel_rdata   = '0;
    for (int i = 0; i < NSLAVE; i++) begin
      if (pick[i])
        pick_offset = pick_offset | slot_offset[i];
      if (sel_reg[i]) begin
        sel_wait  = sel_wait | s_waitrequest[i];
        sel_rdata = sel_rdata | s_readdata[i*WIDTHD +: WIDTHD];
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_LAST) && sel_wait;

  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    offset_next    = offset_reg;
    addr_next      = addr_reg;
    code_next      = code_reg;
    cnt_next       = cnt_reg;
    m_waitrequest  = 1'b0;
    m_readdata     = '0;
    s_read         = '0;
    s_write        = '0;
    err_event      = 1'b0;
    err_event_code = code_reg;

    case (state_reg)
      IDLE: begin
        if (m_read || m_write) begin
          m_waitrequest = 1'b1;
          addr_next     = m_address;
          sel_next      = pick;
          offset_next   = pick_offset;
          cnt_next      = '0;
          if (m_read && m_write) begin
            state_next = ERROR;
            code_next  = 2'd3;
          end else if (|pick) begin
            state_next = ACCESS;
          end else begin
            state_next = ERROR;
            code_next  = 2'd1;
          end
        end
      end
      ACCESS: begin
        cnt_next = cnt_reg + CW'(1);
        if (timeout_hit) begin
          m_readdata     = ERR_DATA;
          err_event      = 1'b1;
          err_event_code = 2'd2;
          state_next     = IDLE;
        end else begin
          s_read        = sel_reg & {NSLAVE{m_read}};
          s_write       = sel_reg & {NSLAVE{m_write}};
          m_waitrequest = sel_wait;
          m_readdata    = sel_rdata;
          if (!sel_wait)
            state_next = IDLE;
        end
      end
      ERROR: begin
        m_readdata = ERR_DATA;
        err_event  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Reset must silence slaves immediately, even mid-transfer.
    if (sreset) begin
      s_read        = '0;
      s_write       = '0;
      m_waitrequest = 1'b1;
    end
  end

  // The first error is held; a completing error beats a simultaneous clear.
  always_comb begin
    err_next         = err_reg;
    err_code_next    = err_code_reg;
    err_address_next = err_address_reg;
    if (err_event && (!err_reg || err_clear)) begin
      err_next         = 1'b1;
      err_code_next    = err_event_code;
      err_address_next = addr_reg;
    end else if (err_clear) begin
      err_next         = 1'b0;
      err_code_next    = 2'd0;
      err_address_next = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (sreset) begin
      state_reg       <= IDLE;
      sel_reg         <= '0;
      offset_reg      <= '0;
      addr_reg        <= '0;
      code_reg        <= 2'd0;
      cnt_reg         <= '0;
      err_reg         <= 1'b0;
      err_code_reg    <= 2'd0;
      err_address_reg <= '0;
    end else begin
      state_reg       <= state_next;
      sel_reg         <= sel_next;
      offset_reg      <= offset_next;
      addr_reg        <= addr_next;
      code_reg        <= code_next;
      cnt_reg         <= cnt_next;
      err_reg         <= err_next;
      err_code_reg    <= err_code_next;
      err_address_reg <= err_address_next;
    end
  end

  assign err         = err_reg;
  assign err_code    = err_code_reg;
  assign err_address = err_address_reg;

endmodule

// File: tb/tb_nano_bus_fabric.sv
// Directed bench for nano_bus_fabric: a vector table of single transfers plus
// hand sequences for reset mid-access, clear/error collision and a disabled window.
module tb_nano_bus_fabric;

  localparam logic [63:0] BASE_P = {16'h0508, 16'h0500, 16'h0400, 16'h0000};
  localparam logic [63:0] SIZE_P = {16'd8, 16'd8, 16'd256, 16'd1024};

  logic         clock, sreset;
  logic [15:0]  m_address;
  logic [31:0]  m_writedata;
  logic         m_read, m_write, m_read_b, m_write_b;
  logic [31:0]  m_readdata, b_readdata;
  logic         m_waitrequest, b_waitrequest;
  logic [63:0]  s_address, b_s_address;
  logic [31:0]  s_writedata, b_s_writedata;
  logic [3:0]   s_read, s_write, b_s_read, b_s_write;
  logic [127:0] s_readdata;
  logic [3:0]   s_waitrequest;
  logic         err_clear, err, b_err;
  logic [1:0]   err_code, b_err_code;
  logic [15:0]  err_address, b_err_address;

  int n_cmp  = 0;
  int n_fail = 0;

  nano_bus_fabric #(.NSLAVE(4), .WIDTHA(16), .WIDTHD(32), .BASE(BASE_P),
    .SIZE(SIZE_P), .ENABLE(4'b1111), .TIMEOUT(16)) dut (
    .clock(clock), .sreset(sreset), .m_address(m_address), .m_writedata(m_writedata),
    .m_read(m_read), .m_write(m_write), .m_readdata(m_readdata),
    .m_waitrequest(m_waitrequest), .s_address(s_address), .s_writedata(s_writedata),
    .s_read(s_read), .s_write(s_write), .s_readdata(s_readdata),
    .s_waitrequest(s_waitrequest), .err_clear(err_clear), .err(err),
    .err_code(err_code), .err_address(err_address));

  nano_bus_fabric #(.NSLAVE(4), .WIDTHA(16), .WIDTHD(32), .BASE(BASE_P),
    .SIZE(SIZE_P), .ENABLE(4'b1011), .TIMEOUT(16)) dut_b (
    .clock(clock), .sreset(sreset), .m_address(m_address), .m_writedata(m_writedata),
    .m_read(m_read_b), .m_write(m_write_b), .m_readdata(b_readdata),
    .m_waitrequest(b_waitrequest), .s_address(b_s_address), .s_writedata(b_s_writedata),
    .s_read(b_s_read), .s_write(b_s_write), .s_readdata(s_readdata),
    .s_waitrequest(s_waitrequest), .err_clear(err_clear), .err(b_err),
    .err_code(b_err_code), .err_address(b_err_address));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Slave model: fixed read data, configurable wait states or stuck stall.
  assign s_readdata = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
  int         slv_wait [4];
  int         wcnt [4];
  logic [3:0] slv_stuck;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_slv
    assign s_waitrequest[gi] = slv_stuck[gi] |
      ((s_read[gi] | s_write[gi]) && (wcnt[gi] < slv_wait[gi]));
    always @(posedge clock) begin
      if (!(s_read[gi] | s_write[gi]))
        wcnt[gi] <= 0;
      else if (s_waitrequest[gi])
        wcnt[gi] <= wcnt[gi] + 1;
    end
  end

  typedef struct {
    logic        clr;
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    int          wt;
    logic [3:0]  stuck;
    int          cyc;
    logic [3:0]  erd;
    logic [3:0]  ewr;
    logic [63:0] esaddr;
    int          estb;
    logic [31:0] erdata;
    logic        eerr;
    logic [1:0]  ecode;
    logic [15:0] eaddr;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    @(posedge clock); #1;
    err_clear = 1'b0;
  endtask

  // Runs one transfer starting just after a rising edge; returns just after
  // the rising edge that ends the completion cycle, strobes deasserted.
  task automatic run_vec(input vec_t v, input int idx);
    int          ncyc, stb;
    logic [3:0]  rs, ws;
    logic [63:0] sa;
    logic [31:0] wd, rdv;
    bit          done;
    if (v.clr) pulse_clear();
    for (int i = 0; i < 4; i++) slv_wait[i] = v.wt;
    slv_stuck   = v.stuck;
    m_address   = v.addr;
    m_read      = v.rd;
    m_write     = v.wr;
    m_writedata = v.wdata;
    ncyc = 0; stb = 0; rs = '0; ws = '0; sa = '0; wd = '0; rdv = '0; done = 0;
    while (!done && ncyc < 64) begin
      @(negedge clock);
      ncyc++;
      rs |= s_read;
      ws |= s_write;
      if ((s_read | s_write) != 4'b0) begin
        stb++;
        sa |= s_address;
        if (s_write != 4'b0) wd = s_writedata;
      end
      if (!m_waitrequest) begin
        done = 1;
        rdv  = m_readdata;
      end
      @(posedge clock); #1;
    end
    m_read    = 1'b0;
    m_write   = 1'b0;
    slv_stuck = '0;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL v%0d_done: got no completion in 64 cycles, expected completion", idx);
    end
    $display("vec %0d addr=%h rd=%0b wr=%0b cycles=%0d strobes=%0d rdata=%h err=%0b code=%0d eaddr=%h",
             idx, v.addr, v.rd, v.wr, ncyc, stb, rdv, err, err_code, err_address);
    check($sformatf("v%0d_cycles", idx), 64'(ncyc), 64'(v.cyc));
    check($sformatf("v%0d_s_read", idx), 64'(rs), 64'(v.erd));
    check($sformatf("v%0d_s_write", idx), 64'(ws), 64'(v.ewr));
    check($sformatf("v%0d_s_address", idx), sa, v.esaddr);
    check($sformatf("v%0d_strobe_cycles", idx), 64'(stb), 64'(v.estb));
    if (v.rd) check($sformatf("v%0d_readdata", idx), 64'(rdv), 64'(v.erdata));
    if (v.ewr != 4'b0) check($sformatf("v%0d_writedata", idx), 64'(wd), 64'(v.wdata));
    check($sformatf("v%0d_err", idx), 64'(err), 64'(v.eerr));
    check($sformatf("v%0d_err_code", idx), 64'(err_code), 64'(v.ecode));
    check($sformatf("v%0d_err_address", idx), 64'(err_address), 64'(v.eaddr));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "time limit reached");
  end

  initial begin
    vec_t unm;
    //          clr addr      rd wr wdata         wt stuck   cyc erd    ewr     esaddr                  estb erdata        eerr code eaddr
    tbl[0]  = '{0, 16'h0412, 1, 0, 32'h0,        0, 4'b0000, 2, 4'b0010, 4'b0000, 64'h0000_0000_0012_0000, 1, 32'hCAFE0001, 0, 2'd0, 16'h0000};
    tbl[1]  = '{0, 16'h050B, 0, 1, 32'h55,       3, 4'b0000, 5, 4'b0000, 4'b1000, 64'h0003_0000_0000_0000, 4, 32'h0,        0, 2'd0, 16'h0000};
    tbl[2]  = '{0, 16'h0003, 1, 0, 32'h0,        0, 4'b0000, 2, 4'b0001, 4'b0000, 64'h0000_0000_0000_0003, 1, 32'hCAFE0000, 0, 2'd0, 16'h0000};
    tbl[3]  = '{0, 16'h03FF, 1, 0, 32'h0,        1, 4'b0000, 3, 4'b0001, 4'b0000, 64'h0000_0000_0000_03FF, 2, 32'hCAFE0000, 0, 2'd0, 16'h0000};
    tbl[4]  = '{0, 16'h04FF, 1, 0, 32'h0,        0, 4'b0000, 2, 4'b0010, 4'b0000, 64'h0000_0000_00FF_0000, 1, 32'hCAFE0001, 0, 2'd0, 16'h0000};
    tbl[5]  = '{0, 16'h0507, 0, 1, 32'hA5A50001, 2, 4'b0000, 4, 4'b0000, 4'b0100, 64'h0000_0007_0000_0000, 3, 32'h0,        0, 2'd0, 16'h0000};
    tbl[6]  = '{0, 16'h7000, 1, 0, 32'h0,        0, 4'b0000, 2, 4'b0000, 4'b0000, 64'h0,                   0, 32'hDEADBEEF, 1, 2'd1, 16'h7000};
    tbl[7]  = '{0, 16'h0510, 1, 0, 32'h0,        0, 4'b0000, 2, 4'b0000, 4'b0000, 64'h0,                   0, 32'hDEADBEEF, 1, 2'd1, 16'h7000};
    tbl[8]  = '{0, 16'h050F, 1, 0, 32'h0,        0, 4'b0000, 2, 4'b1000, 4'b0000, 64'h0007_0000_0000_0000, 1, 32'hCAFE0003, 1, 2'd1, 16'h7000};
    tbl[9]  = '{0, 16'h0412, 1, 1, 32'h99,       0, 4'b0000, 2, 4'b0000, 4'b0000, 64'h0,                   0, 32'hDEADBEEF, 1, 2'd1, 16'h7000};
    tbl[10] = '{1, 16'h0100, 1, 1, 32'h0,        0, 4'b0000, 2, 4'b0000, 4'b0000, 64'h0,                   0, 32'hDEADBEEF, 1, 2'd3, 16'h0100};
    tbl[11] = '{1, 16'h0502, 1, 0, 32'h0,        0, 4'b0100, 17, 4'b0100, 4'b0000, 64'h0000_0002_0000_0000, 15, 32'hDEADBEEF, 1, 2'd2, 16'h0502};
    tbl[12] = '{1, 16'h0412, 1, 0, 32'h0,        0, 4'b0000, 2, 4'b0010, 4'b0000, 64'h0000_0000_0012_0000, 1, 32'hCAFE0001, 0, 2'd0, 16'h0000};
    unm     = '{0, 16'h7000, 1, 0, 32'h0,        0, 4'b0000, 2, 4'b0000, 4'b0000, 64'h0,                   0, 32'hDEADBEEF, 1, 2'd1, 16'h7000};

    for (int i = 0; i < 4; i++) slv_wait[i] = 0;
    slv_stuck = '0; err_clear = 0;
    m_address = 16'h0412; m_writedata = '0; m_read = 1'b1; m_write = 1'b0;
    m_read_b = 1'b0; m_write_b = 1'b0;
    sreset = 1'b1;

    // Reset: master stalled and slaves silent even with a request pending.
    repeat (2) @(posedge clock);
    @(negedge clock);
    $display("reset: waitrequest=%0b s_read=%b s_write=%b", m_waitrequest, s_read, s_write);
    check("rst_waitrequest", 64'(m_waitrequest), 64'd1);
    check("rst_strobes", 64'({s_read, s_write}), 64'd0);
    @(posedge clock); #1;
    sreset = 1'b0; m_read = 1'b0;
    @(negedge clock);
    $display("post-reset idle: waitrequest=%0b err=%0b code=%0d eaddr=%h", m_waitrequest, err, err_code, err_address);
    check("idle_waitrequest", 64'(m_waitrequest), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_err_code", 64'(err_code), 64'd0);
    check("rst_err_address", 64'(err_address), 64'd0);
    @(posedge clock); #1;

    for (int i = 0; i < 13; i++) run_vec(tbl[i], i);

    // sreset raised mid-ACCESS after an error is latched.
    run_vec(unm, 100);
    for (int i = 0; i < 4; i++) slv_wait[i] = 5;
    m_address = 16'h0412; m_read = 1'b1;
    @(negedge clock);
    @(posedge clock); #1;
    @(negedge clock);
    check("rstmid_strobe_before", 64'(s_read), 64'b0010);
    sreset = 1'b1;
    #1;
    $display("reset mid-access: s_read=%b s_write=%b waitrequest=%0b", s_read, s_write, m_waitrequest);
    check("rstmid_strobes", 64'({s_read, s_write}), 64'd0);
    check("rstmid_waitrequest", 64'(m_waitrequest), 64'd1);
    @(posedge clock); #1;
    sreset = 1'b0; m_read = 1'b0;
    @(negedge clock);
    check("rstmid_err", 64'(err), 64'd0);
    check("rstmid_err_code", 64'(err_code), 64'd0);
    check("rstmid_idle_wait", 64'(m_waitrequest), 64'd0);
    @(posedge clock); #1;
    run_vec(tbl[0], 101);

    // err_clear in the same cycle as an error completion: the error wins.
    run_vec(unm, 102);
    m_address = 16'h0123; m_read = 1'b1; m_write = 1'b1;
    @(negedge clock);
    check("race_decode_wait", 64'(m_waitrequest), 64'd1);
    @(posedge clock); #1;
    err_clear = 1'b1;
    @(negedge clock);
    check("race_complete_wait", 64'(m_waitrequest), 64'd0);
    @(posedge clock); #1;
    err_clear = 1'b0; m_read = 1'b0; m_write = 1'b0;
    $display("clear/error race: err=%0b code=%0d eaddr=%h", err, err_code, err_address);
    check("race_err", 64'(err), 64'd1);
    check("race_err_code", 64'(err_code), 64'd3);
    check("race_err_address", 64'(err_address), 64'h0123);

    // Disabled slave 2: 0x500 is unmapped on the second instance.
    m_address = 16'h0500; m_read_b = 1'b1;
    @(negedge clock);
    check("dis_decode_wait", 64'(b_waitrequest), 64'd1);
    @(posedge clock); #1;
    @(negedge clock);
    check("dis_complete_wait", 64'(b_waitrequest), 64'd0);
    check("dis_readdata", 64'(b_readdata), 64'hDEADBEEF);
    check("dis_strobes", 64'({b_s_read, b_s_write}), 64'd0);
    @(posedge clock); #1;
    m_read_b = 1'b0;
    $display("disabled window: err=%0b code=%0d eaddr=%h", b_err, b_err_code, b_err_address);
    check("dis_err", 64'(b_err), 64'd1);
    check("dis_err_code", 64'(b_err_code), 64'd1);
    check("dis_err_address", 64'(b_err_address), 64'h0500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
